hssl_apb_master: RTL

APB initiator that turns single register-access requests into APB3 transfers. Requests arrive on a valid/ready command channel; completions leave on a valid/ready response channel. The block sits between the HSSL configuration source (host command decoder) and the APB register-bank slaves, such as the HSSL routing key/mask/route table. It adds a PREADY timeout so a hung or absent slave cannot stall configuration.

---
 rtl/hssl_apb_pkg.sv | 18 +
 rtl/hssl_apb_master.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hssl_apb_pkg.sv
// Shared types and constants for the HSSL APB initiator and its register-bank address map.
package hssl_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int unsigned DEF_ADDR_WIDTH = 40;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    // Register-bank address fields: section select and word-aligned entry number.
    localparam int unsigned REG_SEC_LSB = 6;
    localparam int unsigned REG_NUM_LSB = 2;

endpackage

// File: rtl/hssl_apb_master.sv
// APB3 initiator: one request in, one APB transfer, one response out, with a PREADY timeout.
module hssl_apb_master
    import hssl_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_vld_in,
    output logic                  req_rdy_out,
    input  logic                  req_write_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [DATA_WIDTH-1:0] req_wdata_in,
    output logic                  rsp_vld_out,
    input  logic                  rsp_rdy_in,
    output logic [DATA_WIDTH-1:0] rsp_rdata_out,
    output logic                  rsp_err_out,
    output logic                  rsp_timeout_out,
    output logic                  apb_psel_out,
    output logic                  apb_penable_out,
    output logic                  apb_pwrite_out,
    output logic [ADDR_WIDTH-1:0] apb_paddr_out,
    output logic [DATA_WIDTH-1:0] apb_pwdata_out,
    input  logic [DATA_WIDTH-1:0] apb_prdata_in,
    input  logic                  apb_pready_in,
    input  logic                  apb_pslverr_in
);

    localparam int unsigned CNT_RAW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W    = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d;
    logic                  rsp_vld_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;

    assign req_rdy_out = (state_q == IDLE);

    // Next-state and next-output decode; every register holds unless a transition updates it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = apb_psel_out;
        penable_d     = apb_penable_out;
        pwrite_d      = apb_pwrite_out;
        paddr_d       = apb_paddr_out;
        pwdata_d      = apb_pwdata_out;
        rsp_vld_d     = rsp_vld_out;
        rsp_rdata_d   = rsp_rdata_out;
        rsp_err_d     = rsp_err_out;
        rsp_timeout_d = rsp_timeout_out;

        case (state_q)
            IDLE: begin
                if (req_vld_in) begin
                    pwrite_d  = req_write_in;
                    paddr_d   = req_addr_in;
                    pwdata_d  = req_wdata_in;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb_pready_in) begin
                    rsp_rdata_d   = apb_pwrite_out ? '0 : apb_prdata_in;
                    rsp_err_d     = apb_pslverr_in;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_vld_d     = 1'b1;
                    state_d       = RESP;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // cnt_q counts completed wait cycles, so this edge closes ACCESS cycle TIMEOUT_CYCLES.
                    if (TO_EN && (cnt_q == CNT_LAST)) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_vld_d     = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_rdy_in) begin
                    rsp_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            apb_pwrite_out  <= 1'b0;
            apb_paddr_out   <= '0;
            apb_pwdata_out  <= '0;
            rsp_vld_out     <= 1'b0;
            rsp_rdata_out   <= '0;
            rsp_err_out     <= 1'b0;
            rsp_timeout_out <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            apb_psel_out    <= psel_d;
            apb_penable_out <= penable_d;
            apb_pwrite_out  <= pwrite_d;
            apb_paddr_out   <= paddr_d;
            apb_pwdata_out  <= pwdata_d;
            rsp_vld_out     <= rsp_vld_d;
            rsp_rdata_out   <= rsp_rdata_d;
            rsp_err_out     <= rsp_err_d;
            rsp_timeout_out <= rsp_timeout_d;
        end
    end

endmodule
